// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and LS.
// LS has priority, bounded by a streak guard; a watchdog aborts stuck accesses.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_LS_BURST = 2,
   parameter int TIMEOUT      = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  ls_ack,
   output logic                  err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_LS_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_BURST);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t                state, state_n;
   logic                  owner_ls, owner_ls_n;
   logic [SW-1:0]         streak, streak_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [DATA_WIDTH-1:0] if_rdata_n, ls_rdata_n, mem_wdata_n;
   logic [ADDR_WIDTH-1:0] mem_addr_n;
   logic                  if_ack_n, ls_ack_n, err_n;
   logic                  mem_en_n, mem_we_n;
   logic                  grant_ls;

   // IF wins a tie only once LS has used up its burst allowance
   assign grant_ls = ls_req && !(if_req && streak == STREAK_MAX);

   always_comb begin
      state_n     = state;
      owner_ls_n  = owner_ls;
      streak_n    = streak;
      cnt_n       = cnt;
      if_rdata_n  = if_rdata;
      ls_rdata_n  = ls_rdata;
      mem_en_n    = mem_en;
      mem_we_n    = mem_we;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      if_ack_n    = 1'b0;
      ls_ack_n    = 1'b0;
      err_n       = 1'b0;
      unique case (state)
         IDLE: begin
            if (if_req || ls_req) begin
               state_n    = ISSUE;
               cnt_n      = '0;
               mem_en_n   = 1'b1;
               owner_ls_n = grant_ls;
               if (grant_ls) begin
                  mem_we_n    = ls_we;
                  mem_addr_n  = ls_addr;
                  mem_wdata_n = ls_wdata;
                  if (!if_req)
                     streak_n = '0;
                  else if (streak != STREAK_MAX)
                     streak_n = streak + SW'(1);
               end else begin
                  mem_we_n    = 1'b0;
                  mem_addr_n  = if_addr;
                  mem_wdata_n = '0;
                  streak_n    = '0;
               end
            end
         end
         ISSUE: begin
            // mem_ready takes precedence over a coinciding timeout
            if (mem_ready || cnt == CNT_MAX) begin
               state_n  = DONE;
               mem_en_n = 1'b0;
               mem_we_n = 1'b0;
               if_ack_n = !owner_ls;
               ls_ack_n = owner_ls;
               err_n    = !mem_ready;
               if (mem_ready && owner_ls && !mem_we)
                  ls_rdata_n = mem_rdata;
               if (mem_ready && !owner_ls)
                  if_rdata_n = mem_rdata;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         owner_ls  <= 1'b0;
         streak    <= '0;
         cnt       <= '0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
         if_ack    <= 1'b0;
         ls_ack    <= 1'b0;
         err       <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_n;
         owner_ls  <= owner_ls_n;
         streak    <= streak_n;
         cnt       <= cnt_n;
         if_rdata  <= if_rdata_n;
         ls_rdata  <= ls_rdata_n;
         if_ack    <= if_ack_n;
         ls_ack    <= ls_ack_n;
         err       <= err_n;
         mem_en    <= mem_en_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level model and a wait-programmable memory.
module tb_mem_port_arbiter;

   localparam int TO   = 15;
   localparam int MAXB = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [31:0] if_rdata, ls_rdata;
   logic        if_ack, ls_ack, err;
   logic        mem_en, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int tests = 0;
   int fails = 0;

   int          wait_cfg = 0;
   int          mem_cyc = 0;
   int          en_cycles = 0;
   bit          use_override = 1'b0;
   logic [31:0] rd_override = '0;
   logic [31:0] mem_store [256];
   logic [31:0] ref_store [256];
   logic [31:0] seen_addr, seen_wdata;
   logic        seen_we;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .MAX_LS_BURST(MAXB), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ack(if_ack),
      .ls_req(ls_req), .ls_we(ls_we),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_ack(ls_ack),
      .err(err),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clock = ~clock;

   // one clock, then memory reacts to what the arbiter now drives
   task automatic step();
      @(posedge clock);
      #1;
      if (mem_en) begin
         en_cycles++;
         if (mem_cyc == wait_cfg) begin
            mem_ready  = 1'b1;
            mem_rdata  = use_override ? rd_override
                                      : mem_store[mem_addr[9:2]];
            seen_addr  = mem_addr;
            seen_we    = mem_we;
            seen_wdata = mem_wdata;
            if (mem_we) mem_store[mem_addr[9:2]] = mem_wdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         mem_cyc++;
      end else begin
         mem_ready = 1'b0;
         mem_cyc   = 0;
         mem_rdata = $urandom;
      end
   endtask

   task automatic do_access(input bit is_ls, input bit we,
                            input logic [31:0] a, input logic [31:0] d,
                            input int wt, output int lat, output int enc,
                            output logic e, output logic ack_after);
      bit got;
      got = 1'b0;
      lat = 0;
      e = 1'b0;
      wait_cfg = wt;
      en_cycles = 0;
      if (is_ls) begin
         ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      while (!got && lat < 100) begin
         step();
         lat++;
         if (is_ls ? ls_ack : if_ack) got = 1'b1;
      end
      enc = en_cycles;
      e = err;
      ls_req = 1'b0;
      if_req = 1'b0;
      if (!got) begin
         tests++; fails++;
         $display("FAIL access_no_ack: ls=%0b addr=%h got no ack, want ack", is_ls, a);
      end
      step();
      ack_after = if_ack | ls_ack;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_req = 0; ls_req = 0; ls_we = 0;
      if_addr = 0; ls_addr = 0; ls_wdata = 0;
      mem_ready = 0; mem_rdata = 0;
      for (int i = 0; i < 256; i++) begin
         mem_store[i] = '0;
         ref_store[i] = '0;
      end
      repeat (3) step();
      tests++;
      if ({mem_en, mem_we, if_ack, ls_ack, err} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctl: got %b want 00000", {mem_en, mem_we, if_ack, ls_ack, err});
      end
      tests++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_mem: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
      end
      tests++;
      if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_rdata: got if=%h ls=%h want 0", if_rdata, ls_rdata);
      end
      reset = 1'b0;
      step();
      tests++;
      if (mem_en !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_req: mem_en got %b want 0", mem_en);
      end
   endtask

   task automatic test_if_read();
      int lat, enc;
      logic e, aa;
      use_override = 1'b1;
      rd_override = 32'hDEADBEEF;
      do_access(1'b0, 1'b0, 32'h40, 32'h0, 0, lat, enc, e, aa);
      tests++;
      if (lat !== 2) begin
         fails++; $display("FAIL if_latency: got %0d want 2", lat);
      end
      tests++;
      if (if_rdata !== 32'hDEADBEEF || e !== 1'b0) begin
         fails++;
         $display("FAIL if_read: got rdata=%h err=%b want deadbeef/0", if_rdata, e);
      end
      tests++;
      if (seen_we !== 1'b0 || seen_addr !== 32'h40 || seen_wdata !== 32'h0) begin
         fails++;
         $display("FAIL if_mem_drive: got we=%b addr=%h wd=%h want 0/40/0", seen_we, seen_addr, seen_wdata);
      end
      tests++;
      if (aa !== 1'b0) begin
         fails++; $display("FAIL if_ack_pulse: got %b after ack want 0", aa);
      end
   endtask

   task automatic test_ls_write();
      int lat, enc;
      logic e, aa;
      use_override = 1'b1;
      rd_override = 32'hCAFEF00D;
      do_access(1'b1, 1'b0, 32'h80, 32'h0, 0, lat, enc, e, aa);
      tests++;
      if (ls_rdata !== 32'hCAFEF00D) begin
         fails++; $display("FAIL ls_read: got %h want cafef00d", ls_rdata);
      end
      rd_override = 32'h99999999;
      do_access(1'b1, 1'b1, 32'h100, 32'h12345678, 0, lat, enc, e, aa);
      tests++;
      if (seen_we !== 1'b1 || seen_addr !== 32'h100 || seen_wdata !== 32'h12345678) begin
         fails++;
         $display("FAIL ls_write_drive: got we=%b addr=%h wd=%h want 1/100/12345678", seen_we, seen_addr, seen_wdata);
      end
      tests++;
      if (ls_rdata !== 32'hCAFEF00D || e !== 1'b0 || lat !== 2) begin
         fails++;
         $display("FAIL ls_write_ack: got rdata=%h err=%b lat=%0d want cafef00d/0/2", ls_rdata, e, lat);
      end
   endtask

   task automatic test_timeout();
      int lat, enc;
      logic e, aa;
      use_override = 1'b1;
      rd_override = 32'h11112222;
      do_access(1'b1, 1'b0, 32'h84, 32'h0, 1000, lat, enc, e, aa);
      tests++;
      if (enc !== TO + 1 || lat !== TO + 2) begin
         fails++;
         $display("FAIL timeout_len: got en=%0d lat=%0d want %0d/%0d", enc, lat, TO + 1, TO + 2);
      end
      tests++;
      if (e !== 1'b1 || ls_rdata !== 32'hCAFEF00D) begin
         fails++;
         $display("FAIL timeout_err: got err=%b rdata=%h want 1/cafef00d", e, ls_rdata);
      end
      rd_override = 32'h0BADCAFE;
      do_access(1'b0, 1'b0, 32'h40, 32'h0, 1, lat, enc, e, aa);
      tests++;
      if (e !== 1'b0 || if_rdata !== 32'h0BADCAFE || lat !== 3) begin
         fails++;
         $display("FAIL after_timeout: got err=%b rdata=%h lat=%0d want 0/0badcafe/3", e, if_rdata, lat);
      end
   endtask

   task automatic test_coincide();
      int lat, enc;
      logic e, aa;
      use_override = 1'b1;
      rd_override = 32'h5A5A1234;
      do_access(1'b0, 1'b0, 32'h48, 32'h0, TO, lat, enc, e, aa);
      tests++;
      if (e !== 1'b0 || if_rdata !== 32'h5A5A1234 || enc !== TO + 1) begin
         fails++;
         $display("FAIL coincide: got err=%b rdata=%h en=%0d want 0/5a5a1234/%0d", e, if_rdata, enc, TO + 1);
      end
   endtask

   task automatic test_reset_mid();
      int lat, enc;
      logic e, aa;
      use_override = 1'b1;
      rd_override = 32'h77777777;
      wait_cfg = 0;
      if_req = 1'b1;
      if_addr = 32'h44;
      step();
      tests++;
      if (mem_en !== 1'b1) begin
         fails++; $display("FAIL mid_issue: mem_en got %b want 1", mem_en);
      end
      reset = 1'b1;
      if_req = 1'b0;
      step();
      tests++;
      if ({if_ack, ls_ack, err, mem_en, mem_we} !== 5'b0 || if_rdata !== 32'h0
          || ls_rdata !== 32'h0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL mid_reset: got ctl=%b ifr=%h lsr=%h addr=%h want 0", {if_ack, ls_ack, err, mem_en, mem_we}, if_rdata, ls_rdata, mem_addr);
      end
      reset = 1'b0;
      step();
      do_access(1'b0, 1'b0, 32'h44, 32'h0, 0, lat, enc, e, aa);
      tests++;
      if (lat !== 2 || if_rdata !== 32'h77777777 || e !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: got lat=%0d rdata=%h err=%b want 2/77777777/0", lat, if_rdata, e);
      end
   endtask

   task automatic test_starvation();
      bit exp_ls [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int k, n;
      use_override = 1'b0;
      wait_cfg = 0;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h88;
      if_req = 1'b1; if_addr = 32'h4C;
      k = 0;
      n = 0;
      while (k < 6 && n < 60) begin
         step();
         n++;
         if (if_ack || ls_ack) begin
            tests++;
            if ((if_ack && ls_ack) || ls_ack !== exp_ls[k]) begin
               fails++;
               $display("FAIL grant_order[%0d]: got ls=%b if=%b want ls=%b", k, ls_ack, if_ack, exp_ls[k]);
            end
            k++;
         end
      end
      ls_req = 1'b0;
      if_req = 1'b0;
      if (k < 6) begin
         tests++; fails++;
         $display("FAIL grant_order_stall: got %0d grants want 6", k);
      end
      repeat (3) step();
   endtask

   task automatic test_random();
      int          kind, w, wt, n, streak_m;
      bit          pi, pl, exp_ls, exp_err;
      logic [31:0] if_a, ls_a, ls_d, m_if_rd, m_ls_rd, v;
      logic        ls_w;
      reset = 1'b1;
      if_req = 0; ls_req = 0;
      repeat (2) step();
      reset = 1'b0;
      step();
      use_override = 1'b0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem_store[i] = v;
         ref_store[i] = v;
      end
      streak_m = 0;
      m_if_rd = '0;
      m_ls_rd = '0;
      for (int r = 0; r < 30; r++) begin
         kind = $urandom_range(0, 2);
         w = $urandom_range(0, 9);
         wt = (w < 6) ? (w % 4) : ((w < 8) ? TO : 1000);
         exp_err = (wt > TO);
         if_a = 32'($urandom_range(0, 15)) << 2;
         ls_a = 32'($urandom_range(0, 15)) << 2;
         ls_w = 1'($urandom_range(0, 1));
         ls_d = $urandom;
         pi = (kind != 1);
         pl = (kind != 0);
         wait_cfg = wt;
         if_req = pi; if_addr = if_a;
         ls_req = pl; ls_we = ls_w; ls_addr = ls_a; ls_wdata = ls_d;
         n = 0;
         while ((pi || pl) && n < 200) begin
            step();
            n++;
            if (if_ack || ls_ack) begin
               exp_ls = pl && !(pi && streak_m == MAXB);
               tests++;
               if ((if_ack && ls_ack) || ls_ack !== exp_ls) begin
                  fails++;
                  $display("FAIL rnd_order r=%0d: got ls=%b if=%b want ls=%b", r, ls_ack, if_ack, exp_ls);
               end
               if (ls_ack) begin
                  streak_m = pi ? ((streak_m < MAXB) ? streak_m + 1 : MAXB) : 0;
                  if (!exp_err && !ls_w) m_ls_rd = ref_store[ls_a[9:2]];
                  if (!exp_err && ls_w) ref_store[ls_a[9:2]] = ls_d;
                  tests++;
                  if (ls_rdata !== m_ls_rd || err !== exp_err) begin
                     fails++;
                     $display("FAIL rnd_ls r=%0d: got rdata=%h err=%b want %h/%b", r, ls_rdata, err, m_ls_rd, exp_err);
                  end
                  if (!exp_err) begin
                     tests++;
                     if (seen_addr !== ls_a || seen_we !== ls_w || (ls_w && seen_wdata !== ls_d)) begin
                        fails++;
                        $display("FAIL rnd_ls_drive r=%0d: got addr=%h we=%b wd=%h want %h/%b/%h", r, seen_addr, seen_we, seen_wdata, ls_a, ls_w, ls_d);
                     end
                  end
                  ls_req = 1'b0;
                  pl = 1'b0;
               end else begin
                  streak_m = 0;
                  if (!exp_err) m_if_rd = ref_store[if_a[9:2]];
                  tests++;
                  if (if_rdata !== m_if_rd || err !== exp_err) begin
                     fails++;
                     $display("FAIL rnd_if r=%0d: got rdata=%h err=%b want %h/%b", r, if_rdata, err, m_if_rd, exp_err);
                  end
                  if_req = 1'b0;
                  pi = 1'b0;
               end
            end
         end
         if (pi || pl) begin
            tests++; fails++;
            $display("FAIL rnd_stall r=%0d: pending if=%b ls=%b want none", r, pi, pl);
            if_req = 1'b0;
            ls_req = 1'b0;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_ls_write();
      test_timeout();
      test_coincide();
      test_reset_mid();
      test_starvation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
